// File: rtl/simon_sequence_ctrl.sv
// Simon Says game sequencer: grows a pseudo-random colour pattern one entry per round,
// replays it on the LED with on/off timing, then checks the player's presses entry by entry.
module simon_sequence_ctrl #(
    parameter int unsigned MAX_LEN    = 16,
    parameter int unsigned ON_CYCLES  = 25_000_000,
    parameter int unsigned OFF_CYCLES = 12_500_000,
    localparam int unsigned LW        = $clog2(MAX_LEN + 1)
) (
    input  logic          CLOCK_50,
    input  logic          resetn,
    input  logic          start,
    input  logic [3:0]    seed_in,
    input  logic          btn_valid,
    input  logic [1:0]    btn_color,
    output logic          led_on,
    output logic [1:0]    led_color,
    output logic          await_input,
    output logic [LW-1:0] level,
    output logic          busy,
    output logic          win,
    output logic          lose
);

    localparam int unsigned MAX_T = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned TW    = $clog2(MAX_T + 1);
    localparam int unsigned DEPTH = 1 << LW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXTEND,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_WAIT_IN,
        S_WIN,
        S_LOSE
    } state_t;

    state_t        state, state_d;
    logic [3:0]    seed, seed_d;
    logic [LW-1:0] len, len_d;
    logic [LW-1:0] idx, idx_d;
    logic [TW-1:0] timer, timer_d;
    logic          mem_we;
    logic [3:0]    nxt_raw, nxt;
    logic [1:0]    color_d;
    logic          last_entry;
    logic [1:0]    mem [DEPTH];

    // Square-based random step: middle bits of seed^2, with a fixed-stride escape from stuck points
    always_comb begin
        nxt_raw = 4'(({4'd0, seed} * {4'd0, seed}) >> 2);
        nxt     = ((nxt_raw == 4'd0) || (nxt_raw == seed)) ? seed + 4'd7 : nxt_raw;
    end

    assign last_entry = (idx == len - LW'(1));

    always_comb begin
        state_d = state;
        seed_d  = seed;
        len_d   = len;
        idx_d   = idx;
        timer_d = timer;
        mem_we  = 1'b0;
        unique case (state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    seed_d  = (seed_in == 4'd0) ? 4'hA : seed_in;
                    len_d   = '0;
                    state_d = S_EXTEND;
                end
            end
            S_EXTEND: begin
                mem_we  = 1'b1;
                seed_d  = nxt;
                len_d   = len + LW'(1);
                idx_d   = '0;
                timer_d = '0;
                state_d = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (timer == TW'(ON_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = S_SHOW_OFF;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            S_SHOW_OFF: begin
                if (timer == TW'(OFF_CYCLES - 1)) begin
                    timer_d = '0;
                    if (last_entry) begin
                        idx_d   = '0;
                        state_d = S_WAIT_IN;
                    end else begin
                        idx_d   = idx + LW'(1);
                        state_d = S_SHOW_ON;
                    end
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            S_WAIT_IN: begin
                if (btn_valid) begin
                    if (btn_color != mem[idx]) begin
                        state_d = S_LOSE;
                    end else if (!last_entry) begin
                        idx_d = idx + LW'(1);
                    end else if (len == LW'(MAX_LEN)) begin
                        state_d = S_WIN;
                    end else begin
                        state_d = S_EXTEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The first entry of a game is written on the same edge it starts being shown, so bypass the RAM
    always_comb begin
        color_d = mem[idx_d];
        if ((state == S_EXTEND) && (len == '0)) begin
            color_d = nxt[1:0];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            seed        <= '0;
            len         <= '0;
            idx         <= '0;
            timer       <= '0;
            led_on      <= 1'b0;
            led_color   <= '0;
            await_input <= 1'b0;
            level       <= '0;
            busy        <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
        end else begin
            state       <= state_d;
            seed        <= seed_d;
            len         <= len_d;
            idx         <= idx_d;
            timer       <= timer_d;
            led_on      <= (state_d == S_SHOW_ON);
            led_color   <= (state_d == S_SHOW_ON) ? color_d : 2'd0;
            await_input <= (state_d == S_WAIT_IN);
            level       <= len_d;
            busy        <= !((state_d == S_IDLE) || (state_d == S_WIN) || (state_d == S_LOSE));
            win         <= (state_d == S_WIN);
            lose        <= (state_d == S_LOSE);
        end
    end

    // Pattern storage needs no reset; entries are always written before they are read
    always_ff @(posedge CLOCK_50) begin
        if (mem_we) begin
            mem[len] <= nxt[1:0];
        end
    end

endmodule

// File: tb/tb_simon_sequence_ctrl.sv
// Bench for simon_sequence_ctrl: scenario tasks with randomized play checked against
// a pattern model computed directly from the seed-squaring rule.
module tb_simon_sequence_ctrl;

    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned ON_C    = 4;
    localparam int unsigned OFF_C   = 2;
    localparam int unsigned LW      = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    seed_in = 4'd0;
    logic          btn_valid = 1'b0;
    logic [1:0]    btn_color = 2'd0;
    logic          led_on;
    logic [1:0]    led_color;
    logic          await_input;
    logic [LW-1:0] level;
    logic          busy;
    logic          win;
    logic          lose;

    int vec  = 0;
    int miss = 0;

    int n_seen;
    int seen_col [8];
    int seen_on  [8];
    int seen_off [8];
    int pat      [MAX_LEN];
    int exp_pat  [4] = '{2, 1, 0, 3};

    simon_sequence_ctrl #(
        .MAX_LEN   (MAX_LEN),
        .ON_CYCLES (ON_C),
        .OFF_CYCLES(OFF_C)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .start      (start),
        .seed_in    (seed_in),
        .btn_valid  (btn_valid),
        .btn_color  (btn_color),
        .led_on     (led_on),
        .led_color  (led_color),
        .await_input(await_input),
        .level      (level),
        .busy       (busy),
        .win        (win),
        .lose       (lose)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int model_next(input int s);
        int n;
        n = ((s * s) / 4) % 16;
        if (n == 0 || n == s) n = (s + 7) % 16;
        return n;
    endfunction

    function automatic void build_pattern(input int sin);
        int s;
        s = (sin == 0) ? 10 : sin;
        for (int i = 0; i < MAX_LEN; i++) begin
            s = model_next(s);
            pat[i] = s % 4;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        start = 1'b0;
        btn_valid = 1'b0;
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic start_game(input int s, input bit with_btn);
        seed_in   = 4'(s);
        start     = 1'b1;
        btn_valid = with_btn;
        btn_color = 2'($urandom);
        step();
        start     = 1'b0;
        btn_valid = 1'b0;
        build_pattern(s);
    endtask

    task automatic press(input int c);
        btn_color = 2'(c);
        btn_valid = 1'b1;
        step();
        btn_valid = 1'b0;
    endtask

    // Watches a replay until input is requested, recording each lit colour and its on/off run lengths
    task automatic run_to_wait(input bit noise, output bit ok);
        bit prev;
        ok = 1'b0;
        n_seen = 0;
        prev = led_on;
        for (int c = 0; c < 200; c++) begin
            if (noise && busy && !await_input) begin
                btn_valid = ($urandom % 3 == 0);
                btn_color = 2'($urandom);
                start     = ($urandom % 4 == 0);
                seed_in   = 4'($urandom);
            end
            step();
            btn_valid = 1'b0;
            start     = 1'b0;
            if (await_input) begin
                ok = 1'b1;
                break;
            end
            if (led_on) begin
                if (!prev && n_seen < 8) begin
                    seen_col[n_seen] = int'(led_color);
                    seen_on[n_seen]  = 0;
                    seen_off[n_seen] = 0;
                    n_seen++;
                end
                if (n_seen > 0) seen_on[n_seen-1]++;
            end else if (n_seen > 0) begin
                seen_off[n_seen-1]++;
            end
            prev = led_on;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) step();
        vec++;
        if ({led_on, led_color, await_input, level, busy, win, lose} !== '0) begin
            miss++;
            $display("FAIL reset_hold: outputs=%b expected all zero",
                     {led_on, led_color, await_input, level, busy, win, lose});
        end
        resetn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            vec++;
            if ({led_on, led_color, await_input, level, busy, win, lose} !== '0) begin
                miss++;
                $display("FAIL reset_idle cycle %0d: outputs=%b expected all zero", c,
                         {led_on, led_color, await_input, level, busy, win, lose});
            end
        end
    endtask

    task automatic test_sequence();
        bit ok;
        do_reset();
        start_game(3, 1'b0);
        vec++;
        if (busy !== 1'b1 || led_on !== 1'b0) begin
            miss++;
            $display("FAIL seq_start: busy=%b led_on=%b expected busy=1 led_on=0", busy, led_on);
        end
        run_to_wait(1'b0, ok);
        vec++;
        if (!ok || n_seen != 1) begin
            miss++;
            $display("FAIL seq_round1: ok=%0d entries=%0d expected ok=1 entries=1", ok, n_seen);
        end
        vec++;
        if (seen_col[0] != 2 || seen_on[0] != ON_C || seen_off[0] != OFF_C) begin
            miss++;
            $display("FAIL seq_timing: colour=%0d on=%0d off=%0d expected colour=2 on=%0d off=%0d",
                     seen_col[0], seen_on[0], seen_off[0], ON_C, OFF_C);
        end
        vec++;
        if (level !== LW'(1) || await_input !== 1'b1) begin
            miss++;
            $display("FAIL seq_level: level=%0d await=%b expected level=1 await=1", level, await_input);
        end
    endtask

    task automatic test_full_game();
        bit ok;
        do_reset();
        start_game(3, 1'b0);
        for (int r = 1; r <= 4; r++) begin
            run_to_wait(1'b0, ok);
            vec++;
            if (!ok || n_seen != r || level !== LW'(r)) begin
                miss++;
                $display("FAIL full_round%0d: ok=%0d entries=%0d level=%0d expected entries=%0d level=%0d",
                         r, ok, n_seen, level, r, r);
            end
            for (int i = 0; i < r && i < n_seen; i++) begin
                vec++;
                if (seen_col[i] != exp_pat[i] || seen_on[i] != ON_C || seen_off[i] != OFF_C) begin
                    miss++;
                    $display("FAIL full_replay r%0d e%0d: colour=%0d on=%0d off=%0d expected %0d/%0d/%0d",
                             r, i, seen_col[i], seen_on[i], seen_off[i], exp_pat[i], ON_C, OFF_C);
                end
            end
            for (int i = 0; i < r; i++) begin
                press(exp_pat[i]);
                if (i < r - 1) begin
                    vec++;
                    if (await_input !== 1'b1 || level !== LW'(r)) begin
                        miss++;
                        $display("FAIL full_press r%0d e%0d: await=%b level=%0d expected await=1 level=%0d",
                                 r, i, await_input, level, r);
                    end
                end
            end
        end
        vec++;
        if (win !== 1'b1 || busy !== 1'b0 || level !== LW'(4) || lose !== 1'b0) begin
            miss++;
            $display("FAIL full_win: win=%b busy=%b level=%0d lose=%b expected win=1 busy=0 level=4 lose=0",
                     win, busy, level, lose);
        end
    endtask

    task automatic test_mistake();
        bit ok;
        do_reset();
        start_game(3, 1'b0);
        run_to_wait(1'b0, ok);
        press(2);
        run_to_wait(1'b0, ok);
        press(2);
        vec++;
        if (await_input !== 1'b1 || lose !== 1'b0) begin
            miss++;
            $display("FAIL mistake_first: await=%b lose=%b expected await=1 lose=0", await_input, lose);
        end
        press(2);
        vec++;
        if (lose !== 1'b1 || level !== LW'(2) || busy !== 1'b0 || await_input !== 1'b0) begin
            miss++;
            $display("FAIL mistake_lose: lose=%b level=%0d busy=%b await=%b expected lose=1 level=2 busy=0 await=0",
                     lose, level, busy, await_input);
        end
        press(1);
        press(0);
        vec++;
        if (lose !== 1'b1 || level !== LW'(2) || win !== 1'b0 || busy !== 1'b0) begin
            miss++;
            $display("FAIL mistake_hold: lose=%b level=%0d win=%b busy=%b expected lose=1 level=2 win=0 busy=0",
                     lose, level, win, busy);
        end
    endtask

    task automatic test_edge_seeds();
        bit ok;
        int seeds [2] = '{0, 1};
        int cols  [2] = '{1, 0};
        for (int k = 0; k < 2; k++) begin
            do_reset();
            start_game(seeds[k], 1'b0);
            run_to_wait(1'b0, ok);
            vec++;
            if (!ok || n_seen != 1 || seen_col[0] != cols[k]) begin
                miss++;
                $display("FAIL edge_seed%0d: ok=%0d entries=%0d colour=%0d expected colour=%0d",
                         seeds[k], ok, n_seen, seen_col[0], cols[k]);
            end
        end
    endtask

    task automatic test_ignored_async();
        bit ok;
        do_reset();
        start_game(3, 1'b0);
        run_to_wait(1'b1, ok);
        vec++;
        if (!ok || n_seen != 1 || seen_col[0] != 2 || seen_on[0] != ON_C || level !== LW'(1)) begin
            miss++;
            $display("FAIL ignore_r1: ok=%0d entries=%0d colour=%0d on=%0d level=%0d expected 1/1/2/%0d/1",
                     ok, n_seen, seen_col[0], seen_on[0], level, ON_C);
        end
        press(2);
        run_to_wait(1'b1, ok);
        vec++;
        if (!ok || n_seen != 2 || seen_col[0] != 2 || seen_col[1] != 1 || level !== LW'(2)) begin
            miss++;
            $display("FAIL ignore_r2: ok=%0d entries=%0d colours=%0d,%0d level=%0d expected 2 entries 2,1 level 2",
                     ok, n_seen, seen_col[0], seen_col[1], level);
        end
        #2 resetn = 1'b0;
        #1;
        vec++;
        if ({led_on, led_color, await_input, level, busy, win, lose} !== '0) begin
            miss++;
            $display("FAIL async_reset: outputs=%b expected all zero",
                     {led_on, led_color, await_input, level, busy, win, lose});
        end
        #2 resetn = 1'b1;
        repeat (3) step();
        press(2);
        vec++;
        if (busy !== 1'b0 || await_input !== 1'b0 || level !== '0 || lose !== 1'b0) begin
            miss++;
            $display("FAIL after_reset_idle: busy=%b await=%b level=%0d lose=%b expected all zero",
                     busy, await_input, level, lose);
        end
    endtask

    task automatic test_random_games();
        bit ok;
        bit lost;
        int s, fail_round, fail_idx, bad;
        do_reset();
        for (int g = 0; g < 10; g++) begin
            s          = $urandom_range(0, 15);
            fail_round = $urandom_range(1, MAX_LEN + 1);
            fail_idx   = (fail_round <= MAX_LEN) ? $urandom_range(0, fail_round - 1) : 0;
            lost       = 1'b0;
            start_game(s, 1'($urandom % 2));
            vec++;
            if (busy !== 1'b1 || win !== 1'b0 || lose !== 1'b0 || level !== '0) begin
                miss++;
                $display("FAIL rand_start g%0d: busy=%b win=%b lose=%b level=%0d expected 1/0/0/0",
                         g, busy, win, lose, level);
            end
            for (int r = 1; r <= MAX_LEN && !lost; r++) begin
                run_to_wait(1'b1, ok);
                bad = 0;
                for (int i = 0; i < r; i++) begin
                    if (i >= n_seen || seen_col[i] != pat[i] || seen_on[i] != ON_C || seen_off[i] != OFF_C)
                        bad++;
                end
                vec++;
                if (!ok || n_seen != r || bad != 0 || level !== LW'(r)) begin
                    miss++;
                    $display("FAIL rand_replay g%0d seed %0d r%0d: ok=%0d entries=%0d bad=%0d level=%0d expected entries=%0d bad=0",
                             g, s, r, ok, n_seen, bad, level, r);
                    if (!ok) lost = 1'b1;
                end
                for (int i = 0; i < r && !lost; i++) begin
                    if (r == fail_round && i == fail_idx) begin
                        press((pat[i] + 1 + int'($urandom % 3)) % 4);
                        vec++;
                        if (lose !== 1'b1 || busy !== 1'b0 || level !== LW'(r)) begin
                            miss++;
                            $display("FAIL rand_lose g%0d r%0d: lose=%b busy=%b level=%0d expected lose=1 busy=0 level=%0d",
                                     g, r, lose, busy, level, r);
                        end
                        lost = 1'b1;
                    end else begin
                        press(pat[i]);
                    end
                end
            end
            if (!lost) begin
                vec++;
                if (win !== 1'b1 || busy !== 1'b0 || level !== LW'(MAX_LEN)) begin
                    miss++;
                    $display("FAIL rand_win g%0d seed %0d: win=%b busy=%b level=%0d expected win=1 busy=0 level=%0d",
                             g, s, win, busy, level, MAX_LEN);
                end
            end
            if (busy) do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_full_game();
        test_mistake();
        test_edge_seeds();
        test_ignored_async();
        test_random_games();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
